muldiv_unit: RTL and testbench

Iterative multiply/divide unit holding the MIPS HI/LO registers; sits directly downstream of the register file and consumes its two read ports as operands.
Executes MULT, MULTU, DIV and DIVU over multiple cycles, one bit per cycle, and reports Busy/Done so the control unit can stall the PC and MFHI/MFLO.
Also accepts MTHI/MTLO writes.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/muldiv_step.sv | 32 +++
 rtl/muldiv_unit.sv | 120 ++++++++++++
 tb/tb_muldiv_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multiply/divide unit.
// Op codes match the 2-bit Op field; DEFAULT_WIDTH is the architectural HI/LO width.
package mips_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int ITER_COUNT    = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restore-subtract for divide.
// acc holds {upper, lower}; lower is the multiplier (shifted out) or dividend/quotient.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] diff;

  always_comb begin
    acc_next = acc;
    sum      = '0;
    diff     = '0;
    if (!is_div) begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      // Trial subtract from the remainder shifted left by one dividend bit.
      diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, operand};
      if (!diff[WIDTH+1])
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; Start at E0 -> HI/LO written at E0+33, Done pulses after.
// Busy covers the whole operation; Start and MTHI/MTLO are ignored while Busy.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(ITER_COUNT);
  localparam logic [CW-1:0] LAST = CW'(ITER_COUNT - 1);

  state_e             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   opb, a_raw;
  logic               is_div, q_neg, r_neg;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign signed_op = ~Op[0];
  assign a_mag = (signed_op && OperandA[WIDTH-1]) ? -OperandA : OperandA;
  assign b_mag = (signed_op && OperandB[WIDTH-1]) ? -OperandB : OperandB;

  assign prod_fix = q_neg ? -acc : acc;
  assign quot_fix = q_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = r_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign Busy = (state != IDLE);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (opb),
    .acc_next (acc_next)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      HI     <= '0;
      LO     <= '0;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (HiWrite) HI <= WriteData;
          if (LoWrite) LO <= WriteData;
          if (Start) begin
            cnt    <= '0;
            acc    <= {{WIDTH{1'b0}}, a_mag};
            opb    <= b_mag;
            a_raw  <= OperandA;
            is_div <= Op[1];
            q_neg  <= signed_op & (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
            r_neg  <= signed_op & OperandA[WIDTH-1];
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          Done <= 1'b1;
          if (!is_div) begin
            HI <= prod_fix[2*WIDTH-1:WIDTH];
            LO <= prod_fix[WIDTH-1:0];
          end else if (opb == '0) begin
            // Divide by zero never traps: all-ones quotient, raw dividend as remainder.
            HI <= a_raw;
            LO <= '1;
          end else begin
            HI <= rem_fix;
            LO <= quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector table plus hand-written sequences for muldiv_unit.
module tb_muldiv_unit;
  import mips_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] OperandA = '0, OperandB = '0, WriteData = '0;
  logic        HiWrite = 1'b0, LoWrite = 1'b0;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  muldiv_unit dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Waits out Busy (bounded) and returns how many sampled cycles it was high.
  task automatic wait_idle(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      @(negedge Clock);
    end
  endtask

  task automatic run_op(input string name, input op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    @(negedge Clock);
    Op = op; OperandA = a; OperandB = b; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    OperandA = ~a; OperandB = b ^ 32'h5a5a_0f0f; Op = ~op;
    wait_idle(n);
    check({name, " busy_cycles"}, 32'(n), 32'd33);
    check({name, " done"}, {31'b0, Done}, 32'd1);
    check({name, " hi"}, HI, ehi);
    check({name, " lo"}, LO, elo);
    @(negedge Clock);
    check({name, " done_drop"}, {31'b0, Done}, 32'd0);
  endtask

  initial begin
    int n;
    int pulses;

    vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4] = '{OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[5] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

    // Reset state
    repeat (2) @(negedge Clock);
    check("rst busy", {31'b0, Busy}, 32'd0);
    check("rst done", {31'b0, Done}, 32'd0);
    check("rst hi", HI, 32'd0);
    check("rst lo", LO, 32'd0);
    Reset = 1'b1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // Start and HiWrite together: write lands at E0, product overwrites later
    @(negedge Clock);
    Op = OP_MULTU; OperandA = 32'd2; OperandB = 32'd3; Start = 1'b1;
    HiWrite = 1'b1; WriteData = 32'h55;
    @(negedge Clock);
    Start = 1'b0; HiWrite = 1'b0;
    check("simul hi_write", HI, 32'h55);
    wait_idle(n);
    check("simul hi", HI, 32'd0);
    check("simul lo", LO, 32'd6);

    // MULT 6*7 with Start/HiWrite re-pulsed mid-operation
    @(negedge Clock);
    Op = OP_MULT; OperandA = 32'd6; OperandB = 32'd7; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (4) @(negedge Clock);
    Op = OP_DIV; Start = 1'b1; HiWrite = 1'b1; WriteData = 32'h1234;
    @(negedge Clock);
    Start = 1'b0; HiWrite = 1'b0;
    wait_idle(n);
    check("busy_ignore cycles", 32'(n + 5), 32'd33);
    check("busy_ignore hi", HI, 32'd0);
    check("busy_ignore lo", LO, 32'd42);
    @(negedge Clock);
    LoWrite = 1'b1; WriteData = 32'hCAFEF00D;
    @(negedge Clock);
    LoWrite = 1'b0;
    check("mtlo lo", LO, 32'hCAFEF00D);
    check("mtlo hi", HI, 32'd0);
    check("mtlo busy", {31'b0, Busy}, 32'd0);

    // Reset mid-divide aborts with no partial result and no Done
    @(negedge Clock);
    Op = OP_DIVU; OperandA = 32'd1000; OperandB = 32'd3; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (9) @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("abort busy", {31'b0, Busy}, 32'd0);
    check("abort hi", HI, 32'd0);
    check("abort lo", LO, 32'd0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock);
      if (Done === 1'b1) pulses++;
    end
    check("abort no_done", 32'(pulses), 32'd0);
    check("abort lo_after", LO, 32'd0);
    run_op("post_reset", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
